// File: rtl/preg_free_list.sv
// Physical register free list for the rename stage.
// Circular buffer of free register numbers with a speculative allocate
// head, a retired head and an insert tail. Allocation is show-ahead and
// all-or-nothing; flush rewinds the speculative head to the retired head.
module preg_free_list #(
  parameter int PHYS_REGS = 32,
  parameter int PR_ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_valid,
  input  logic [1:0]             alloc_cnt,
  output logic                   alloc_ready,
  output logic [2*PR_ADDR_W-1:0] alloc_regs,
  input  logic [1:0]             free_valid,
  input  logic [2*PR_ADDR_W-1:0] free_regs,
  input  logic [1:0]             retire_cnt,
  input  logic                   flush,
  output logic [PR_ADDR_W:0]     free_count,
  output logic                   err
);

  localparam int DEPTH = PHYS_REGS - 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PR_ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PR_ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     spec_head, ret_head, tail;
  logic [CNT_W-1:0]     count;
  // Number of granted-but-not-retired entries between ret_head and
  // spec_head; kept explicitly because equal pointers are ambiguous.
  logic [CNT_W-1:0]     spec_cnt;
  logic                 err_q;

  logic [PTR_W-1:0]     spec_head_nx, ret_head_nx, tail_nx;
  logic [CNT_W-1:0]     count_nx, spec_cnt_nx;
  logic                 err_nx;
  logic                 we0, we1;
  logic [PTR_W-1:0]     waddr0, waddr1;

  logic [CNT_W-1:0]     grant_n, ret_n, spec_left, base;
  logic                 illegal, ret_over, ovf;
  logic                 wr0, wr1;
  logic [PR_ADDR_W-1:0] free0, free1;

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [CNT_W-1:0] n);
    logic [CNT_W:0] s;
    s = {{(CNT_W+1-PTR_W){1'b0}}, p} + {1'b0, n};
    if (s >= {1'b0, DEPTH_C}) s = s - {1'b0, DEPTH_C};
    return s[PTR_W-1:0];
  endfunction

  assign free0      = free_regs[PR_ADDR_W-1:0];
  assign free1      = free_regs[2*PR_ADDR_W-1:PR_ADDR_W];
  assign alloc_regs = {mem[ptr_add(spec_head, CNT_W'(1))], mem[spec_head]};
  assign free_count = count;
  assign err        = err_q;

  // Grant decision, retirement, flush rewind and free insertion for next state.
  always_comb begin
    illegal      = alloc_valid && (alloc_cnt == 2'd3);
    alloc_ready  = !flush && (count >= CNT_W'(alloc_cnt)) && (alloc_cnt != 2'd3);
    grant_n      = (alloc_valid && alloc_ready) ? CNT_W'(alloc_cnt) : '0;

    ret_n        = CNT_W'(retire_cnt);
    ret_over     = 1'b0;
    if (ret_n > spec_cnt) begin
      ret_over = 1'b1;
      ret_n    = spec_cnt;
    end
    ret_head_nx  = ptr_add(ret_head, ret_n);
    spec_left    = spec_cnt - ret_n;

    // Flush retires first, then hands the remaining speculative entries back.
    if (flush) begin
      spec_head_nx = ret_head_nx;
      spec_cnt_nx  = '0;
      base         = count + spec_left;
    end else begin
      spec_head_nx = ptr_add(spec_head, grant_n);
      spec_cnt_nx  = spec_left + grant_n;
      base         = count - grant_n;
    end

    wr0      = free_valid[0] && (free0 >= PR_ADDR_W'(2));
    wr1      = free_valid[1] && (free1 >= PR_ADDR_W'(2));
    ovf      = 1'b0;
    we0      = 1'b0;
    we1      = 1'b0;
    waddr0   = tail;
    waddr1   = tail;
    tail_nx  = tail;
    count_nx = base;
    if (wr0) begin
      if (count_nx < DEPTH_C) begin
        we0      = 1'b1;
        waddr0   = tail_nx;
        tail_nx  = ptr_add(tail_nx, CNT_W'(1));
        count_nx = count_nx + CNT_W'(1);
      end else begin
        ovf = 1'b1;
      end
    end
    if (wr1) begin
      if (count_nx < DEPTH_C) begin
        we1      = 1'b1;
        waddr1   = tail_nx;
        tail_nx  = ptr_add(tail_nx, CNT_W'(1));
        count_nx = count_nx + CNT_W'(1);
      end else begin
        ovf = 1'b1;
      end
    end

    err_nx = err_q | illegal | ret_over | ovf;
  end

  // State update; reset reloads the list with registers 2..PHYS_REGS-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= PR_ADDR_W'(i + 2);
      spec_head <= '0;
      ret_head  <= '0;
      tail      <= '0;
      count     <= DEPTH_C;
      spec_cnt  <= '0;
      err_q     <= 1'b0;
    end else begin
      if (we0) mem[waddr0] <= free0;
      if (we1) mem[waddr1] <= free1;
      spec_head <= spec_head_nx;
      ret_head  <= ret_head_nx;
      tail      <= tail_nx;
      count     <= count_nx;
      spec_cnt  <= spec_cnt_nx;
      err_q     <= err_nx;
    end
  end

endmodule

// File: tb/tb_preg_free_list.sv
// Directed bench for preg_free_list: reset image, drain, refill from empty,
// partial requests, flush rewind, overflow/illegal flags and a long
// wrap-around run against a queue model.
module tb_preg_free_list;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [1:0]  alloc_cnt;
  logic        alloc_ready;
  logic [9:0]  alloc_regs;
  logic [1:0]  free_valid;
  logic [9:0]  free_regs;
  logic [1:0]  retire_cnt;
  logic        flush;
  logic [5:0]  free_count;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  preg_free_list #(.PHYS_REGS(32), .PR_ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_cnt(alloc_cnt), .alloc_ready(alloc_ready),
    .alloc_regs(alloc_regs), .free_valid(free_valid), .free_regs(free_regs),
    .retire_cnt(retire_cnt), .flush(flush), .free_count(free_count), .err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alloc_valid = 1'b0; alloc_cnt = 2'd0; free_valid = 2'b00;
    free_regs = '0; retire_cnt = 2'd0; flush = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    alloc_cnt = 2'd2;
    #1;
    n_cmp++; if (free_count !== 6'd30) begin n_err++; $display("FAIL reset_count got %0d want 30", free_count); end
    n_cmp++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b want 1", alloc_ready); end
    n_cmp++; if (alloc_regs !== {5'd3, 5'd2}) begin n_err++; $display("FAIL reset_regs got %h want %h", alloc_regs, {5'd3, 5'd2}); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got %0b want 0", err); end
    alloc_cnt = 2'd0;
  endtask

  task automatic test_drain();
    logic [9:0] exp;
    for (int i = 0; i < 15; i++) begin
      alloc_valid = 1'b1; alloc_cnt = 2'd2;
      #1;
      exp = {5'(2*i+3), 5'(2*i+2)};
      n_cmp++; if (alloc_regs !== exp) begin n_err++; $display("FAIL drain_regs[%0d] got %h want %h", i, alloc_regs, exp); end
      step();
    end
    alloc_valid = 1'b0; alloc_cnt = 2'd1;
    #1;
    n_cmp++; if (free_count !== 6'd0) begin n_err++; $display("FAIL drain_count got %0d want 0", free_count); end
    n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL drain_ready got %0b want 0", alloc_ready); end
  endtask

  task automatic test_free_empty();
    free_valid = 2'b11; free_regs = {5'd9, 5'd7}; alloc_cnt = 2'd1;
    #1;
    n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL empty_bypass_ready got %0b want 0", alloc_ready); end
    step();
    free_valid = 2'b00; free_regs = '0;
    n_cmp++; if (free_count !== 6'd2) begin n_err++; $display("FAIL empty_count got %0d want 2", free_count); end
    n_cmp++; if (alloc_regs !== {5'd9, 5'd7}) begin n_err++; $display("FAIL empty_regs got %h want %h", alloc_regs, {5'd9, 5'd7}); end
  endtask

  task automatic test_min_count();
    alloc_valid = 1'b1; alloc_cnt = 2'd1;
    step();
    alloc_cnt = 2'd2;
    #1;
    n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL short_ready got %0b want 0", alloc_ready); end
    step();
    n_cmp++; if (free_count !== 6'd1) begin n_err++; $display("FAIL short_count got %0d want 1", free_count); end
    n_cmp++; if (alloc_regs[4:0] !== 5'd9) begin n_err++; $display("FAIL short_slot0 got %0d want 9", alloc_regs[4:0]); end
    alloc_cnt = 2'd1;
    #1;
    n_cmp++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL last_ready got %0b want 1", alloc_ready); end
    step();
    alloc_valid = 1'b0; alloc_cnt = 2'd0;
    n_cmp++; if (free_count !== 6'd0) begin n_err++; $display("FAIL last_count got %0d want 0", free_count); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL last_err got %0b want 0", err); end
  endtask

  task automatic test_flush();
    do_reset();
    alloc_valid = 1'b1; alloc_cnt = 2'd2;
    step();
    step();
    alloc_valid = 1'b0; alloc_cnt = 2'd0; retire_cnt = 2'd2;
    step();
    retire_cnt = 2'd0; flush = 1'b1; alloc_valid = 1'b1; alloc_cnt = 2'd1;
    #1;
    n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got %0b want 0", alloc_ready); end
    step();
    clear_inputs();
    n_cmp++; if (free_count !== 6'd28) begin n_err++; $display("FAIL flush_count got %0d want 28", free_count); end
    n_cmp++; if (alloc_regs !== {5'd5, 5'd4}) begin n_err++; $display("FAIL flush_regs got %h want %h", alloc_regs, {5'd5, 5'd4}); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL flush_err got %0b want 0", err); end
  endtask

  task automatic test_overflow();
    do_reset();
    free_valid = 2'b11; free_regs = {5'd1, 5'd0};
    step();
    n_cmp++; if (free_count !== 6'd30) begin n_err++; $display("FAIL zero_free_count got %0d want 30", free_count); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL zero_free_err got %0b want 0", err); end
    free_valid = 2'b01; free_regs = {5'd0, 5'd6};
    step();
    clear_inputs();
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL ovf_err got %0b want 1", err); end
    n_cmp++; if (free_count !== 6'd30) begin n_err++; $display("FAIL ovf_count got %0d want 30", free_count); end
    n_cmp++; if (alloc_regs !== {5'd3, 5'd2}) begin n_err++; $display("FAIL ovf_regs got %h want %h", alloc_regs, {5'd3, 5'd2}); end
  endtask

  task automatic test_illegal();
    do_reset();
    alloc_valid = 1'b1; alloc_cnt = 2'd3;
    #1;
    n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL cnt3_ready got %0b want 0", alloc_ready); end
    step();
    clear_inputs();
    n_cmp++; if (free_count !== 6'd30) begin n_err++; $display("FAIL cnt3_count got %0d want 30", free_count); end
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL cnt3_err got %0b want 1", err); end
    do_reset();
    retire_cnt = 2'd1;
    step();
    clear_inputs();
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL over_retire_err got %0b want 1", err); end
    n_cmp++; if (free_count !== 6'd30) begin n_err++; $display("FAIL over_retire_count got %0d want 30", free_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc_valid = 1'b1; alloc_cnt = 2'd2;
    step();
    alloc_cnt = 2'd3;
    step();
    rst = 1'b1; alloc_cnt = 2'd2; free_valid = 2'b01; free_regs = {5'd0, 5'd20}; retire_cnt = 2'd1;
    step();
    rst = 1'b0;
    clear_inputs();
    n_cmp++; if (free_count !== 6'd30) begin n_err++; $display("FAIL mid_rst_count got %0d want 30", free_count); end
    n_cmp++; if (alloc_regs !== {5'd3, 5'd2}) begin n_err++; $display("FAIL mid_rst_regs got %h want %h", alloc_regs, {5'd3, 5'd2}); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL mid_rst_err got %0b want 0", err); end
  endtask

  task automatic test_wrap();
    logic [4:0] fl[$];
    logic [4:0] inuse[$];
    logic [4:0] f0, f1;
    logic [1:0] prev_grant;
    int cnt, nf, g;
    logic exp_ready;
    do_reset();
    for (int r = 2; r < 32; r++) fl.push_back(5'(r));
    prev_grant = 2'd0;
    for (int c = 0; c < 60; c++) begin
      cnt = (c % 4 == 3) ? 0 : ((c % 2 == 1) ? 1 : 2);
      nf  = (inuse.size() >= 6) ? 2 : ((inuse.size() >= 3) ? 1 : 0);
      f0  = (nf >= 1) ? inuse[0] : 5'd0;
      f1  = (nf == 2) ? inuse[1] : 5'd0;
      alloc_valid = 1'b1;
      alloc_cnt   = 2'(cnt);
      retire_cnt  = prev_grant;
      free_valid  = (nf == 2) ? 2'b11 : ((nf == 1) ? 2'b01 : 2'b00);
      free_regs   = {f1, f0};
      #1;
      exp_ready = (fl.size() >= cnt);
      n_cmp++; if (free_count !== 6'(fl.size())) begin n_err++; $display("FAIL wrap_count[%0d] got %0d want %0d", c, free_count, fl.size()); end
      n_cmp++; if (alloc_ready !== exp_ready) begin n_err++; $display("FAIL wrap_ready[%0d] got %0b want %0b", c, alloc_ready, exp_ready); end
      if (fl.size() >= 1) begin
        n_cmp++; if (alloc_regs[4:0] !== fl[0]) begin n_err++; $display("FAIL wrap_slot0[%0d] got %0d want %0d", c, alloc_regs[4:0], fl[0]); end
      end
      if (fl.size() >= 2) begin
        n_cmp++; if (alloc_regs[9:5] !== fl[1]) begin n_err++; $display("FAIL wrap_slot1[%0d] got %0d want %0d", c, alloc_regs[9:5], fl[1]); end
      end
      step();
      g = exp_ready ? cnt : 0;
      for (int k = 0; k < nf; k++) fl.push_back(inuse.pop_front());
      for (int k = 0; k < g; k++) inuse.push_back(fl.pop_front());
      prev_grant = 2'(g);
    end
    clear_inputs();
    retire_cnt = prev_grant;
    step();
    retire_cnt = 2'd0;
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL wrap_err got %0b want 0", err); end
    n_cmp++; if (free_count !== 6'(fl.size())) begin n_err++; $display("FAIL wrap_final_count got %0d want %0d", free_count, fl.size()); end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_drain();
    test_free_empty();
    test_min_count();
    test_flush();
    test_overflow();
    test_illegal();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
